pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register that generalises the fixed-field MEM/WB register into one reusable block for every boundary of the 5-stage core (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an opaque payload bus of configurable width and decodes the shared `stall` vector at a configurable stage index. It also adds behaviour the fixed-field registers lack:
- explicit valid bit
- payload masking on invalid input
- flush counting
- optional saturating performance counters for hold, bubble and flush cycles

---
 rtl/pipe_stage_reg.sv | 118 +++++++++++
 tb/tb_pipe_stage_reg.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register (valid/payload/debug tag) with optional hold/bubble/flush counters (PIPE_STAGE_PERF_CNT_EN).
// Latency: 1 cycle, all outputs registered.
// Backpressure: stall[STAGE_IDX+1:STAGE_IDX] selects advance/bubble/hold; flush overrides all stall combinations.
module pipe_stage_reg #(
  parameter int unsigned         DATA_W    = 32,
  parameter int unsigned         DBG_W     = 32,
  parameter int unsigned         STALL_W   = 6,
  parameter int unsigned         STAGE_IDX = 4,
  parameter logic [DATA_W-1:0]   NOP_VALUE = {DATA_W{1'b0}},
  parameter int unsigned         CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_W-1:0]  stall,
  input  logic                flush,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [DBG_W-1:0]    in_dbg,
  input  logic                perf_clr,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic [DBG_W-1:0]    out_dbg,
  output logic [CNT_W-1:0]    hold_cnt,
  output logic [CNT_W-1:0]    bubble_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);

  typedef enum logic [1:0] {
    ACT_ADVANCE,
    ACT_BUBBLE,
    ACT_HOLD,
    ACT_FLUSH
  } act_t;

  logic us;
  logic ds;
  act_t act;

  assign us = stall[STAGE_IDX];
  assign ds = stall[STAGE_IDX+1];

  // us=0 with ds=1 never comes from the stall controller; it simply advances.
  always_comb begin
    act = ACT_ADVANCE;
    if (flush)          act = ACT_FLUSH;
    else if (us && !ds) act = ACT_BUBBLE;
    else if (us && ds)  act = ACT_HOLD;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= NOP_VALUE;
      out_dbg   <= '0;
    end else begin
      case (act)
        ACT_FLUSH: begin
          out_valid <= 1'b0;
          out_data  <= NOP_VALUE;
          out_dbg   <= '0;
        end
        ACT_BUBBLE: begin
          // Keep the stalled instruction's tag visible in the trace.
          out_valid <= 1'b0;
          out_data  <= NOP_VALUE;
          out_dbg   <= in_dbg;
        end
        ACT_ADVANCE: begin
          out_valid <= in_valid;
          out_data  <= in_valid ? in_data : NOP_VALUE;
          out_dbg   <= in_dbg;
        end
        default: begin
          out_valid <= out_valid;
          out_data  <= out_data;
          out_dbg   <= out_dbg;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_CNT_EN
  logic [CNT_W-1:0] hold_q;
  logic [CNT_W-1:0] bubble_q;
  logic [CNT_W-1:0] flush_q;

  // Clear beats a same-edge event; counters saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (rst || perf_clr) begin
      hold_q   <= '0;
      bubble_q <= '0;
      flush_q  <= '0;
    end else begin
      if (act == ACT_HOLD && hold_q != {CNT_W{1'b1}})
        hold_q <= hold_q + CNT_W'(1);
      if (act == ACT_BUBBLE && bubble_q != {CNT_W{1'b1}})
        bubble_q <= bubble_q + CNT_W'(1);
      if (act == ACT_FLUSH && flush_q != {CNT_W{1'b1}})
        flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign hold_cnt   = hold_q;
  assign bubble_cnt = bubble_q;
  assign flush_cnt  = flush_q;

  logic unused_stall;
  assign unused_stall = ^stall;
`else
  assign hold_cnt   = '0;
  assign bubble_cnt = '0;
  assign flush_cnt  = '0;

  logic unused_inputs;
  assign unused_inputs = ^{stall, perf_clr};
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg with a non-zero NOP and 4-bit counters to reach saturation quickly.
module tb_pipe_stage_reg;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef PIPE_STAGE_PERF_CNT_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic [31:0] in_dbg;
  logic        perf_clr;
  logic        out_valid;
  logic [31:0] out_data;
  logic [31:0] out_dbg;
  logic [3:0]  hold_cnt;
  logic [3:0]  bubble_cnt;
  logic [3:0]  flush_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  pipe_stage_reg #(
    .DATA_W(32), .DBG_W(32), .STALL_W(6), .STAGE_IDX(4),
    .NOP_VALUE(NOP), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_dbg(in_dbg),
    .perf_clr(perf_clr), .out_valid(out_valid), .out_data(out_data),
    .out_dbg(out_dbg), .hold_cnt(hold_cnt), .bubble_cnt(bubble_cnt),
    .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = '0; flush = 1'b0; perf_clr = 1'b0;
    in_valid = 1'b0; in_data = '0; in_dbg = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = '0; flush = 1'b0; perf_clr = 1'b0;
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_dbg = 32'hCAFE_0000;
    step();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %0h want 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== NOP) $display("FAIL reset_data got %h want %h", out_data, NOP); else pass_cnt++;
    total_cnt++; if (out_dbg !== 32'h0) $display("FAIL reset_dbg got %h want 0", out_dbg); else pass_cnt++;
    total_cnt++; if ({hold_cnt, bubble_cnt, flush_cnt} !== 12'h0) $display("FAIL reset_cnts got %h want 0", {hold_cnt, bubble_cnt, flush_cnt}); else pass_cnt++;
    rst = 1'b0; in_data = 32'hA5A5_0001; in_dbg = 32'h0000_0001;
    step();
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL first_valid got %0h want 1", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== 32'hA5A5_0001) $display("FAIL first_data got %h want a5a50001", out_data); else pass_cnt++;
    total_cnt++; if (out_dbg !== 32'h0000_0001) $display("FAIL first_dbg got %h want 00000001", out_dbg); else pass_cnt++;
  endtask

  task automatic test_bubble();
    do_reset();
    stall = 6'b010000; in_valid = 1'b1; in_data = 32'h0BAD_0BAD; in_dbg = 32'h2402_0005;
    step();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL bubble_valid got %0h want 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== NOP) $display("FAIL bubble_data got %h want %h", out_data, NOP); else pass_cnt++;
    total_cnt++; if (out_dbg !== 32'h2402_0005) $display("FAIL bubble_dbg got %h want 24020005", out_dbg); else pass_cnt++;
    total_cnt++; if (bubble_cnt !== 4'(PERF)) $display("FAIL bubble_cnt got %0d want %0d", bubble_cnt, PERF); else pass_cnt++;
    total_cnt++; if (hold_cnt !== 4'd0) $display("FAIL bubble_hold_cnt got %0d want 0", hold_cnt); else pass_cnt++;
  endtask

  // Leaves the DUT holding 0x1234 with hold_cnt at 3 for test_flush.
  task automatic test_hold();
    do_reset();
    in_valid = 1'b1; in_data = 32'h0000_1234; in_dbg = 32'h0000_000D;
    step();
    stall = 6'b110000; in_valid = 1'b0; in_data = 32'hBEEF_BEEF; in_dbg = 32'h0000_00EE;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++; if (out_data !== 32'h0000_1234) $display("FAIL hold_data[%0d] got %h want 00001234", i, out_data); else pass_cnt++;
    end
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL hold_valid got %0h want 1", out_valid); else pass_cnt++;
    total_cnt++; if (out_dbg !== 32'h0000_000D) $display("FAIL hold_dbg got %h want 0000000d", out_dbg); else pass_cnt++;
    total_cnt++; if (hold_cnt !== 4'(3 * PERF)) $display("FAIL hold_cnt got %0d want %0d", hold_cnt, 3 * PERF); else pass_cnt++;
  endtask

  task automatic test_flush();
    flush = 1'b1; stall = 6'b110000; in_valid = 1'b1; in_data = 32'h7777_7777; in_dbg = 32'h0000_0099;
    step();
    flush = 1'b0;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_valid got %0h want 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== NOP) $display("FAIL flush_data got %h want %h", out_data, NOP); else pass_cnt++;
    total_cnt++; if (out_dbg !== 32'h0) $display("FAIL flush_dbg got %h want 0", out_dbg); else pass_cnt++;
    total_cnt++; if (flush_cnt !== 4'(PERF)) $display("FAIL flush_cnt got %0d want %0d", flush_cnt, PERF); else pass_cnt++;
    total_cnt++; if (hold_cnt !== 4'(3 * PERF)) $display("FAIL flush_hold_cnt got %0d want %0d", hold_cnt, 3 * PERF); else pass_cnt++;
  endtask

  task automatic test_invalid_mask();
    stall = 6'b000000; in_valid = 1'b0; in_data = 32'hFFFF_FFFF; in_dbg = 32'h0000_0077;
    step();
    total_cnt++; if (out_data !== NOP) $display("FAIL mask_data got %h want %h", out_data, NOP); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL mask_valid got %0h want 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_dbg !== 32'h0000_0077) $display("FAIL mask_dbg got %h want 00000077", out_dbg); else pass_cnt++;
  endtask

  // Downstream-only stall and unrelated stall bits must still advance.
  task automatic test_other_stall_bits();
    stall = 6'b101111; in_valid = 1'b1; in_data = 32'h0000_0055; in_dbg = 32'h0000_0056;
    step();
    total_cnt++; if (out_data !== 32'h0000_0055) $display("FAIL dsonly_data got %h want 00000055", out_data); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL dsonly_valid got %0h want 1", out_valid); else pass_cnt++;
    stall = 6'b000000;
  endtask

  task automatic test_saturation();
    do_reset();
    in_valid = 1'b1; in_data = 32'h0000_4242; in_dbg = 32'h0000_0042;
    step();
    stall = 6'b110000;
    repeat (20) step();
    total_cnt++; if (hold_cnt !== 4'(15 * PERF)) $display("FAIL sat_hold_cnt got %0d want %0d", hold_cnt, 15 * PERF); else pass_cnt++;
    total_cnt++; if (out_data !== 32'h0000_4242) $display("FAIL sat_data got %h want 00004242", out_data); else pass_cnt++;
    perf_clr = 1'b1;
    step();
    total_cnt++; if (hold_cnt !== 4'd0) $display("FAIL clr_hold_cnt got %0d want 0", hold_cnt); else pass_cnt++;
    flush = 1'b1;
    step();
    flush = 1'b0; perf_clr = 1'b0;
    total_cnt++; if (flush_cnt !== 4'd0) $display("FAIL clr_flush_cnt got %0d want 0", flush_cnt); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL clr_flush_valid got %0h want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    in_valid = 1'b1; in_data = 32'h0000_3333; in_dbg = 32'h0000_0033;
    step();
    stall = 6'b110000;
    step();
    rst = 1'b1;
    step();
    total_cnt++; if (out_data !== NOP) $display("FAIL rsthold_data got %h want %h", out_data, NOP); else pass_cnt++;
    total_cnt++; if (hold_cnt !== 4'd0) $display("FAIL rsthold_cnt got %0d want 0", hold_cnt); else pass_cnt++;
    rst = 1'b0;
    step();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL posthold_valid got %0h want 0", out_valid); else pass_cnt++;
    total_cnt++; if (hold_cnt !== 4'(PERF)) $display("FAIL posthold_cnt got %0d want %0d", hold_cnt, PERF); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_bubble();
    test_hold();
    test_flush();
    test_invalid_mask();
    test_other_stall_bits();
    test_saturation();
    test_reset_mid_hold();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
